// File: rtl/nco_cordic_wavegen.sv
// Quadrature waveform generator: phase accumulator driving an iterative
// rotation-mode CORDIC, plus sawtooth, square and triangle shapes.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for enable, outputs hold
// LOAD   | sample theta, step accumulator, quadrant fold
// ITER   | one CORDIC micro-rotation per cycle
// DONE   | register outputs, strobe out_valid
module nco_cordic_wavegen #(
    parameter int PHASE_WIDTH = 32,
    parameter int WAVE_WIDTH  = 16,
    parameter int ITERATIONS  = 14
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   enable,
    input  logic [PHASE_WIDTH-1:0] freq_in,
    input  logic [PHASE_WIDTH-1:0] phase_off,
    input  logic [1:0]             mode,
    output logic [WAVE_WIDTH-1:0]  wave_outsen,
    output logic [WAVE_WIDTH-1:0]  wave_outcos,
    output logic                   out_valid,
    output logic                   busy
);

    localparam int PW   = PHASE_WIDTH;
    localparam int WW   = WAVE_WIDTH;
    localparam int DW   = WAVE_WIDTH + 2;
    localparam int IW   = $clog2(ITERATIONS + 1);
    localparam int MAXV = 2**(WW-1) - 1;
    localparam longint K_INT = (longint'(607253) * MAXV + 500000) / 1000000;

    // x/y carry one fractional bit; the second extra bit is growth headroom.
    localparam logic signed [DW-1:0] K_FIX   = DW'(2 * K_INT);
    localparam logic signed [DW-1:0] ONE_S   = 1;
    localparam logic signed [DW-1:0] MAX_S   = DW'(MAXV);
    localparam logic [PW-1:0]        QUARTER = {2'b01, {(PW-2){1'b0}}};
    localparam logic [WW-1:0]        MID     = {1'b1, {(WW-1){1'b0}}};
    localparam logic [WW-1:0]        POS_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0]        NEG_MAX = {1'b1, {(WW-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        phase_acc;
    logic [WW:0]          theta_hi;
    logic [1:0]           mode_q;
    logic signed [DW-1:0] x, y, x_ld, y_ld, x_rot, y_rot, x_sh, y_sh;
    logic [PW-1:0]        z, z_ld, z_rot, atan_val, theta_nxt;
    logic [IW-1:0]        iter_idx;
    logic [WW-1:0]        sin_sel, cos_sel, tri_u;

    // atan(2^-i) as a fraction of a full turn, 32-bit scale, rescaled to PW.
    function automatic logic [PW-1:0] atan_lut(input int i);
        logic [31:0] v32;
        case (i)
            0:  v32 = 32'h2000_0000;
            1:  v32 = 32'h12E4_051E;
            2:  v32 = 32'h09FB_385B;
            3:  v32 = 32'h0511_11D4;
            4:  v32 = 32'h028B_0D43;
            5:  v32 = 32'h0145_D7E1;
            6:  v32 = 32'h00A2_F61E;
            7:  v32 = 32'h0051_7C55;
            8:  v32 = 32'h0028_BE53;
            9:  v32 = 32'h0014_5F2F;
            10: v32 = 32'h000A_2F98;
            11: v32 = 32'h0005_17CC;
            12: v32 = 32'h0002_8BE6;
            13: v32 = 32'h0001_45F3;
            14: v32 = 32'h0000_A2FA;
            15: v32 = 32'h0000_517D;
            default: v32 = 32'(64'd683565276 >> i);
        endcase
        return PW'({v32, 32'b0} >> (64 - PW));
    endfunction

    function automatic logic [WW-1:0] sat_round(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] r;
        r = v + ONE_S;
        r = r >>> 1;
        if (r > MAX_S)
            return POS_MAX;
        else if (r < -MAX_S)
            return NEG_MAX;
        else
            return r[WW-1:0];
    endfunction

    assign busy      = (state != S_IDLE);
    assign theta_nxt = phase_acc + phase_off;
    assign x_sh      = x >>> iter_idx;
    assign y_sh      = y >>> iter_idx;
    assign atan_val  = atan_lut(int'(iter_idx));
    assign tri_u     = theta_hi[WW-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ITER;
            S_ITER:  if (iter_idx == IW'(ITERATIONS - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = enable ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        z_ld = theta_nxt;
        x_ld = K_FIX;
        y_ld = '0;
        case (theta_nxt[PW-1:PW-2])
            2'b01: begin z_ld = theta_nxt - QUARTER; x_ld = '0; y_ld = K_FIX;  end
            2'b10: begin z_ld = theta_nxt + QUARTER; x_ld = '0; y_ld = -K_FIX; end
            default: ;
        endcase
    end

    always_comb begin
        x_rot = x - y_sh;
        y_rot = y + x_sh;
        z_rot = z - atan_val;
        if (z[PW-1]) begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_val;
        end
    end

    always_comb begin
        sin_sel = '0;
        cos_sel = '0;
        case (mode_q)
            2'b00: begin sin_sel = sat_round(y); cos_sel = sat_round(x); end
            2'b01: sin_sel = theta_hi[WW -: WW] ^ MID;
            2'b10: sin_sel = theta_hi[WW] ? NEG_MAX : POS_MAX;
            default: sin_sel = (theta_hi[WW] ? ~tri_u : tri_u) - MID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state       <= S_IDLE;
            phase_acc   <= '0;
            theta_hi    <= '0;
            mode_q      <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            iter_idx    <= '0;
            wave_outsen <= '0;
            wave_outcos <= '0;
            out_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    theta_hi  <= theta_nxt[PW-1 -: WW+1];
                    phase_acc <= phase_acc + freq_in;
                    mode_q    <= mode;
                    x         <= x_ld;
                    y         <= y_ld;
                    z         <= z_ld;
                    iter_idx  <= '0;
                end
                S_ITER: begin
                    x        <= x_rot;
                    y        <= y_rot;
                    z        <= z_rot;
                    iter_idx <= iter_idx + IW'(1);
                end
                S_DONE: begin
                    wave_outsen <= sin_sel;
                    wave_outcos <= cos_sel;
                    out_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_cordic_wavegen.sv
// Randomized bench for nco_cordic_wavegen against a real-arithmetic
// reference of phase, waveform shape and sample timing.
`timescale 1ns/1ps

module tb_nco_cordic_wavegen;

    localparam int TOL_SIN = 6;  // CORDIC angle residual after 14 steps plus rounding

    logic        clk = 1'b0;
    logic        rst_in;
    logic        enable;
    logic [31:0] freq_in;
    logic [31:0] phase_off;
    logic [1:0]  mode;
    logic [15:0] wave_outsen;
    logic [15:0] wave_outcos;
    logic        out_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_acc;
    logic [31:0] cf_freq [64];
    logic [31:0] cf_off  [64];
    logic [1:0]  cf_mode [64];

    nco_cordic_wavegen #(.PHASE_WIDTH(32), .WAVE_WIDTH(16), .ITERATIONS(14)) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .enable      (enable),
        .freq_in     (freq_in),
        .phase_off   (phase_off),
        .mode        (mode),
        .wave_outsen (wave_outsen),
        .wave_outcos (wave_outcos),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic void model(input logic [31:0] th, input logic [1:0] md,
                                  output int es, output int ec);
        real a;
        int  u;
        ec = 0;
        case (md)
            2'd0: begin
                a  = 6.283185307179586 * real'(th) / 4294967296.0;
                es = int'(32767.0 * $sin(a));
                ec = int'(32767.0 * $cos(a));
            end
            2'd1: es = int'(th >> 16) - 32768;
            2'd2: es = th[31] ? -32767 : 32767;
            default: begin
                u  = int'((th >> 15) & 32'hFFFF);
                es = (th[31] ? 65535 - u : u) - 32768;
            end
        endcase
    endfunction

    task automatic apply_cfg(input int k);
        freq_in   = cf_freq[k];
        phase_off = cf_off[k];
        mode      = cf_mode[k];
    endtask

    task automatic set_cfg(input int k, input logic [31:0] f, input logic [31:0] o, input logic [1:0] m);
        cf_freq[k] = f;
        cf_off[k]  = o;
        cf_mode[k] = m;
    endtask

    // Runs n back-to-back samples; each next config lands mid-ITER of the current one.
    task automatic run_stream(input int n, input string tag);
        int          cnt;
        int          es, ec, tol, vld_seen, busy_seen;
        logic [31:0] th;
        logic [1:0]  last_md;
        es = 0; ec = 0; last_md = 2'd0;
        apply_cfg(0);
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (cnt == ((k == 0) ? 4 : 2)) begin
                    if (k + 1 < n) apply_cfg(k + 1);
                    else enable = 1'b0;
                end
            end while (!out_valid && cnt < 40);
            check_val({tag, (k == 0) ? " latency" : " period"}, cnt, (k == 0) ? 17 : 16, 0);
            th    = m_acc + cf_off[k];
            m_acc = m_acc + cf_freq[k];
            model(th, cf_mode[k], es, ec);
            last_md = cf_mode[k];
            tol = (cf_mode[k] == 2'd0) ? TOL_SIN : 0;
            check_val({tag, " sin"}, int'($signed(wave_outsen)), es, tol);
            check_val({tag, " cos"}, int'($signed(wave_outcos)), ec, tol);
        end
        check_val({tag, " busy after last"}, int'(busy), 0, 0);
        vld_seen = 0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) vld_seen++;
            if (busy) busy_seen++;
        end
        check_val({tag, " idle valid"}, vld_seen, 0, 0);
        check_val({tag, " idle busy"}, busy_seen, 0, 0);
        tol = (last_md == 2'd0) ? TOL_SIN : 0;
        check_val({tag, " hold sin"}, int'($signed(wave_outsen)), es, tol);
        check_val({tag, " hold cos"}, int'($signed(wave_outcos)), ec, tol);
    endtask

    initial begin
        rst_in    = 1'b0;
        enable    = 1'b0;
        freq_in   = '0;
        phase_off = '0;
        mode      = '0;
        m_acc     = '0;
        #1;
        check_val("reset sin", int'(wave_outsen), 0, 0);
        check_val("reset cos", int'(wave_outcos), 0, 0);
        check_val("reset valid", int'(out_valid), 0, 0);
        check_val("reset busy", int'(busy), 0, 0);
        repeat (3) @(negedge clk);
        rst_in = 1'b1;

        for (int k = 0; k < 4; k++) set_cfg(k, 32'h4000_0000, 32'h0, 2'd0);
        run_stream(4, "quadrature");

        for (int k = 0; k < 8; k++)  set_cfg(k, 32'h2000_0000, 32'h0, 2'd2);
        for (int k = 8; k < 16; k++) set_cfg(k, 32'h2000_0000, 32'h0, 2'd3);
        run_stream(16, "square_tri");

        // Abort in the middle of the rotations
        set_cfg(0, 32'h1234_5678, 32'h0, 2'd0);
        apply_cfg(0);
        @(negedge clk);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        rst_in = 1'b0;
        #1;
        check_val("abort sin", int'(wave_outsen), 0, 0);
        check_val("abort cos", int'(wave_outcos), 0, 0);
        check_val("abort valid", int'(out_valid), 0, 0);
        check_val("abort busy", int'(busy), 0, 0);
        enable = 1'b0;
        m_acc  = '0;
        repeat (2) @(negedge clk);
        check_val("abort hold valid", int'(out_valid), 0, 0);
        rst_in = 1'b1;

        set_cfg(0, 32'hFFFF_FFF0, 32'h0, 2'd1);
        set_cfg(1, 32'h0000_0020, 32'h0, 2'd1);
        set_cfg(2, 32'h4000_0000, 32'h0, 2'd1);
        set_cfg(3, 32'h0, 32'h4000_0000, 2'd0);
        set_cfg(4, 32'h0, 32'h4000_0000, 2'd0);
        run_stream(5, "wrap_offset");

        for (int k = 0; k < 24; k++)
            set_cfg(k, (k % 6 == 5) ? 32'h0 : $urandom(), $urandom(), 2'($urandom_range(0, 3)));
        run_stream(24, "random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
